// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 mux path.
// Grants are registered one-hot, with a per-grant hold limit (HOLD_MAX)
// that forces rotation when other requesters are waiting. The muxed data
// bit and its valid flag follow the grant by one cycle.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       q,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic       idle_found;
  logic [1:0] idle_idx;
  logic       next_found;
  logic [1:0] next_idx;
  logic [1:0] next_ptr;
  logic       others;
  logic       at_limit;

  // First requesting index in the order start, start+1, start+2, start+3.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Arbitration candidates: from ptr when idle, from sel+1 on release or
  // rotation. On rotation req[sel] is still set, but it is searched last,
  // so any other requester wins first.
  always_comb begin
    next_ptr                 = sel + 2'd1;
    {idle_found, idle_idx}   = pick(ptr, req);
    {next_found, next_idx}   = pick(next_ptr, req);
    others                   = |(req & ~gnt);
    at_limit                 = (cnt == 4'(HOLD_MAX));
  end

  // Grant state machine plus the registered data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      q     <= 1'b0;
      valid <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      valid <= |gnt;
      if (|gnt) begin
        q <= d[sel];
      end

      case (state)
        IDLE: begin
          if (idle_found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << idle_idx;
            sel   <= idle_idx;
            cnt   <= 4'd1;
          end
        end

        GRANT: begin
          if (!req[sel]) begin
            ptr <= next_ptr;
            if (next_found) begin
              gnt <= 4'b0001 << next_idx;
              sel <= next_idx;
              cnt <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (at_limit) begin
            cnt <= 4'd1;
            if (others) begin
              ptr <= next_ptr;
              gnt <= 4'b0001 << next_idx;
              sel <= next_idx;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=1)
// driven by the same stimulus and compared each cycle against an
// integer-level round-robin model, plus literal scenario checks.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] gnt0, gnt1;
  logic [1:0] sel0, sel1;
  logic       q0, q1, valid0, valid1;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt0), .sel(sel0), .q(q0), .valid(valid0)
  );

  mux_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .gnt(gnt1), .sel(sel1), .q(q1), .valid(valid1)
  );

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  // Model state per instance: owner index (-1 when idle), rr pointer,
  // cycles held, last select, data and valid.
  int hold_lim [2] = '{4, 1};
  int own      [2];
  int ptr_m    [2];
  int cnt_m    [2];
  int sel_m    [2];
  int q_m      [2];
  int val_m    [2];

  function automatic int pick(int start, logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (start + i) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(int k);
    int w;
    logic [3:0] rest;
    if (rst) begin
      own[k] = -1; ptr_m[k] = 0; cnt_m[k] = 0;
      sel_m[k] = 0; q_m[k] = 0; val_m[k] = 0;
      return;
    end
    if (own[k] >= 0) q_m[k] = d[sel_m[k]];
    val_m[k] = (own[k] >= 0) ? 1 : 0;
    if (own[k] < 0) begin
      w = pick(ptr_m[k], req);
      if (w >= 0) begin own[k] = w; sel_m[k] = w; cnt_m[k] = 1; end
    end else if (!req[own[k]]) begin
      ptr_m[k] = (own[k] + 1) % 4;
      w = pick(ptr_m[k], req);
      if (w >= 0) begin own[k] = w; sel_m[k] = w; cnt_m[k] = 1; end
      else own[k] = -1;
    end else if (cnt_m[k] == hold_lim[k]) begin
      rest = req;
      rest[own[k]] = 1'b0;
      if (rest != 0) begin
        ptr_m[k] = (own[k] + 1) % 4;
        w = pick(ptr_m[k], rest);
        own[k] = w; sel_m[k] = w;
      end
      cnt_m[k] = 1;
    end else begin
      cnt_m[k] = cnt_m[k] + 1;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, then compare both
  // instances against it shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    if (checking) begin
      chk("gnt_h4",   int'(gnt0),   own[0] < 0 ? 0 : (1 << own[0]));
      chk("sel_h4",   int'(sel0),   sel_m[0]);
      chk("valid_h4", int'(valid0), val_m[0]);
      chk("q_h4",     int'(q0),     q_m[0]);
      chk("gnt_h1",   int'(gnt1),   own[1] < 0 ? 0 : (1 << own[1]));
      chk("sel_h1",   int'(sel1),   sel_m[1]);
      chk("valid_h1", int'(valid1), val_m[1]);
      chk("q_h1",     int'(q1),     q_m[1]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    d   = '0;
    #2;
    step();
    checking = 1'b1;
    step();
    chk("reset_gnt",   int'(gnt0),   0);
    chk("reset_sel",   int'(sel0),   0);
    chk("reset_valid", int'(valid0), 0);
    chk("reset_q",     int'(q0),     0);

    // Single requester 2 with its data bit high.
    rst = 1'b0; req = 4'b0100; d = 4'b0100;
    step();
    chk("r027_gnt", int'(gnt0), 4);
    chk("r027_sel", int'(sel0), 2);
    step();
    chk("r027_q",     int'(q0),     1);
    chk("r027_valid", int'(valid0), 1);

    // All requests drop: idle next edge, valid low one edge later, sel kept.
    req = 4'b0000;
    step();
    chk("r032_gnt", int'(gnt0), 0);
    chk("r032_sel", int'(sel0), 2);
    step();
    chk("r032_valid", int'(valid0), 0);

    // All four requesting: groups of four grants vs per-cycle rotation.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      step();
      chk("r028_gnt_h4", int'(gnt0), 1 << ((k / 4) % 4));
      chk("r022_gnt_h1", int'(gnt1), 1 << (k % 4));
    end

    // Reset while requester 2 holds the grant.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 9; k++) step();
    chk("r031_pre_gnt", int'(gnt0), 4);
    rst = 1'b1;
    step();
    chk("r031_gnt",   int'(gnt0),   0);
    chk("r031_valid", int'(valid0), 0);
    rst = 1'b0;
    step();
    chk("r031_next_gnt", int'(gnt0), 1);

    // Requester 1 releases while 3 and 0 ask: search starts at 2.
    do_reset();
    req = 4'b0010;
    step();
    chk("r029_pre_gnt", int'(gnt0), 2);
    step();
    req = 4'b1001;
    step();
    chk("r029_gnt_h4", int'(gnt0), 8);
    chk("r029_gnt_h1", int'(gnt1), 8);

    // Lone requester 0 keeps the grant past the hold limit.
    do_reset();
    req = 4'b0001; d = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("r030_gnt", int'(gnt0), 1);
      if (k > 0) chk("r030_valid", int'(valid0), 1);
    end

    // Randomized traffic with sticky requests and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      d   = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
